// File: rtl/capi_put_align_seq.sv
// Put-transfer sequencer in front of the put-data byte aligner: latches one command, holds the
// offset sideband, streams tagged source beats and counts aligned output beats until done.
module capi_put_align_seq #(
  parameter int LENW   = 13,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_v,
  output logic            cmd_r,
  input  logic [3:0]      cmd_off,
  input  logic [LENW-1:0] cmd_len,
  input  logic            in_v,
  output logic            in_r,
  input  logic [127:0]    in_d,
  output logic            o_v,
  input  logic            o_r,
  output logic [127:0]    o_d,
  output logic [3:0]      o_c,
  output logic            o_e,
  output logic            o_a_v,
  output logic [3:0]      o_a_d,
  input  logic            mon_v,
  input  logic            mon_r,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int CW = LENW - 3;
  localparam int SW = (SETTLE < 2) ? 1 : $clog2(SETTLE);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_XFER, S_DRAIN, S_DONE} state_t;

  state_t          state_r, next_s;
  logic [CW-1:0]   in_rem_r, out_rem_r;
  logic [3:0]      lastc_r;
  logic [SW-1:0]   settle_cnt_r;
  logic            cmd_r_r, busy_r, done_r, err_r, o_a_v_r;
  logic [3:0]      o_a_d_r;

  logic [LENW:0]   len_full_s;
  logic [LENW+1:0] in_sum_s, out_sum_s;
  logic [CW-1:0]   in_beats_s, out_beats_s;
  logic            accept_s, last_s, in_fire_s, window_s, mon_fire_s, mon_cnt_s, mon_err_s;

  // A zero length encodes a full 2**LENW byte transfer; ceil(x/16) via +15 then drop the low nibble.
  assign len_full_s  = (cmd_len == {LENW{1'b0}}) ? {1'b1, {LENW{1'b0}}} : {1'b0, cmd_len};
  assign in_sum_s    = {1'b0, len_full_s} + (LENW+2)'(15);
  assign out_sum_s   = {1'b0, len_full_s} + {{(LENW-2){1'b0}}, cmd_off} + (LENW+2)'(15);
  assign in_beats_s  = in_sum_s[4 +: CW];
  assign out_beats_s = out_sum_s[4 +: CW];

  assign accept_s   = (state_r == S_IDLE) && cmd_v && cmd_r_r;
  assign last_s     = (in_rem_r == CW'(1));
  assign in_fire_s  = (state_r == S_XFER) && in_v && o_r;
  assign window_s   = (state_r == S_SETTLE) || (state_r == S_XFER) || (state_r == S_DRAIN);
  assign mon_fire_s = mon_v && mon_r;
  assign mon_cnt_s  = mon_fire_s && window_s && (out_rem_r != {CW{1'b0}});
  assign mon_err_s  = mon_fire_s && !mon_cnt_s;

  // Data path is a straight combinational pass while streaming.
  assign o_v   = (state_r == S_XFER) && in_v;
  assign in_r  = (state_r == S_XFER) && o_r;
  assign o_d   = in_d;
  assign o_e   = (state_r == S_XFER) && last_s;
  assign o_c   = ((state_r == S_XFER) && last_s) ? lastc_r : 4'd0;
  assign cmd_r = cmd_r_r;
  assign busy  = busy_r;
  assign done  = done_r;
  assign err   = err_r;
  assign o_a_v = o_a_v_r;
  assign o_a_d = o_a_d_r;

  // Next-state logic; DRAIN exits as soon as the final output beat is seen.
  always_comb begin
    next_s = state_r;
    case (state_r)
      S_IDLE:   if (accept_s) next_s = S_SETTLE; else next_s = S_IDLE;
      S_SETTLE: if (settle_cnt_r == SETTLE_LAST) next_s = S_XFER; else next_s = S_SETTLE;
      S_XFER:   if (in_fire_s && last_s) next_s = S_DRAIN; else next_s = S_XFER;
      S_DRAIN: begin
        if ((out_rem_r == {CW{1'b0}}) || ((out_rem_r == CW'(1)) && mon_cnt_s)) next_s = S_DONE;
        else next_s = S_DRAIN;
      end
      S_DONE:   next_s = S_IDLE;
      default:  next_s = S_IDLE;
    endcase
  end

  // State, counters and registered status/sideband outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= S_IDLE;
      in_rem_r     <= {CW{1'b0}};
      out_rem_r    <= {CW{1'b0}};
      lastc_r      <= 4'd0;
      settle_cnt_r <= {SW{1'b0}};
      cmd_r_r      <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      o_a_v_r      <= 1'b0;
      o_a_d_r      <= 4'd0;
    end else begin
      state_r <= next_s;
      cmd_r_r <= (next_s == S_IDLE);
      busy_r  <= (next_s != S_IDLE);
      done_r  <= (next_s == S_DONE);
      err_r   <= mon_err_s;
      o_a_v_r <= (next_s != S_IDLE);
      if (accept_s) begin
        o_a_d_r      <= cmd_off;
        in_rem_r     <= in_beats_s;
        out_rem_r    <= out_beats_s;
        lastc_r      <= cmd_len[3:0];
        settle_cnt_r <= {SW{1'b0}};
      end else begin
        if (next_s == S_IDLE) o_a_d_r <= 4'd0;
        else                  o_a_d_r <= o_a_d_r;
        if (in_fire_s) in_rem_r <= in_rem_r - CW'(1);
        else           in_rem_r <= in_rem_r;
        if (mon_cnt_s) out_rem_r <= out_rem_r - CW'(1);
        else           out_rem_r <= out_rem_r;
        if (state_r == S_SETTLE) settle_cnt_r <= settle_cnt_r + SW'(1);
        else                     settle_cnt_r <= settle_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_capi_put_align_seq.sv
// Self-checking bench for capi_put_align_seq: table of transfers with a beat scoreboard,
// plus hand-written reset and stray-monitor-beat sequences.
module tb_capi_put_align_seq;

  localparam int LENW = 13;

  logic            clk = 1'b0;
  logic            reset;
  logic            cmd_v;
  logic            cmd_r;
  logic [3:0]      cmd_off;
  logic [LENW-1:0] cmd_len;
  logic            in_v;
  logic            in_r;
  logic [127:0]    in_d;
  logic            o_v;
  logic            o_r;
  logic [127:0]    o_d;
  logic [3:0]      o_c;
  logic            o_e;
  logic            o_a_v;
  logic [3:0]      o_a_d;
  logic            mon_v;
  logic            mon_r;
  logic            busy;
  logic            done;
  logic            err;

  capi_put_align_seq #(.LENW(LENW), .SETTLE(1)) dut (
    .clk(clk), .reset(reset),
    .cmd_v(cmd_v), .cmd_r(cmd_r), .cmd_off(cmd_off), .cmd_len(cmd_len),
    .in_v(in_v), .in_r(in_r), .in_d(in_d),
    .o_v(o_v), .o_r(o_r), .o_d(o_d), .o_c(o_c), .o_e(o_e),
    .o_a_v(o_a_v), .o_a_d(o_a_d),
    .mon_v(mon_v), .mon_r(mon_r),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]      off;
    logic [LENW-1:0] len;
    bit              rnd;
    int              ein;
    int              eout;
    logic [3:0]      elc;
  } vec_t;

  typedef struct {
    logic [127:0] d;
    logic [3:0]   c;
    logic         e;
  } beat_t;

  beat_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic accept_cmd(input logic [3:0] off, input logic [LENW-1:0] len);
    int n;
    @(negedge clk);
    cmd_v = 1'b1; cmd_off = off; cmd_len = len;
    n = 0;
    #1;
    while (!cmd_r && n < 50) begin
      @(negedge clk); #1; n++;
    end
    check("cmd_accept_timeout", 128'(n < 50), 128'(1));
    @(negedge clk);
    cmd_v = 1'b0;
    #1;
    check("settle_o_a_d", 128'(o_a_d), 128'(off));
    check("settle_o_a_v", 128'(o_a_v), 128'(1));
    check("settle_busy", 128'(busy), 128'(1));
    check("settle_cmd_r", 128'(cmd_r), 128'(0));
  endtask

  task automatic run_vec(input vec_t v);
    logic [127:0] data[$];
    beat_t b, got;
    int moved, mons, last_mon, done_cyc, errs_seen, ad_bad;
    bit got_done, mon;
    moved = 0; mons = 0; last_mon = -10; done_cyc = -1; errs_seen = 0; ad_bad = 0; got_done = 0;
    accept_cmd(v.off, v.len);
    for (int i = 0; i < v.ein; i++) begin
      b.d = {$urandom, $urandom, $urandom, $urandom};
      b.c = (i == v.ein - 1) ? v.elc : 4'd0;
      b.e = (i == v.ein - 1);
      data.push_back(b.d);
      sb.push_back(b);
    end
    for (int cyc = 0; cyc < 8000 && !got_done; cyc++) begin
      @(negedge clk);
      in_v = (moved < v.ein) && (v.rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
      in_d = in_v ? data[moved] : 128'd0;
      o_r  = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      mon  = (mons < v.eout) && (v.rnd ? ((mons < moved) && ($urandom_range(0, 1) == 1))
                                       : (moved == v.ein));
      mon_v = mon; mon_r = mon;
      #1;
      if (done) begin
        got_done = 1'b1; done_cyc = cyc;
      end
      if (o_v && o_r) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_beat", 128'(1), 128'(0));
        end else begin
          got = sb.pop_front();
          check("beat_data", o_d, got.d);
          check("beat_tag", {123'd0, o_c, o_e}, {123'd0, got.c, got.e});
        end
        moved++;
      end
      if (mon) begin
        mons++; last_mon = cyc;
      end
      if (err) errs_seen++;
      if (busy && (o_a_d != v.off)) ad_bad++;
    end
    in_v = 1'b0; mon_v = 1'b0; mon_r = 1'b0;
    check("done_seen", 128'(got_done), 128'(1));
    check("in_beats", 128'(moved), 128'(v.ein));
    check("mon_beats", 128'(mons), 128'(v.eout));
    check("no_err", 128'(errs_seen), 128'(0));
    check("o_a_d_stable", 128'(ad_bad), 128'(0));
    if (!v.rnd) check("done_latency", 128'(done_cyc - last_mon), 128'(1));
    @(negedge clk); #1;
    check("post_done", 128'(done), 128'(0));
    check("post_o_a_d", 128'(o_a_d), 128'(0));
    check("post_o_a_v", 128'(o_a_v), 128'(0));
    check("post_cmd_r", 128'(cmd_r), 128'(1));
    check("post_busy", 128'(busy), 128'(0));
    sb.delete();
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{off: 4'd0,  len: 13'd64,  rnd: 1'b0, ein: 4,   eout: 4,   elc: 4'd0};
    vecs[1] = '{off: 4'd5,  len: 13'd20,  rnd: 1'b0, ein: 2,   eout: 2,   elc: 4'd4};
    vecs[2] = '{off: 4'd15, len: 13'd16,  rnd: 1'b0, ein: 1,   eout: 2,   elc: 4'd0};
    vecs[3] = '{off: 4'd3,  len: 13'd100, rnd: 1'b1, ein: 7,   eout: 7,   elc: 4'd4};
    vecs[4] = '{off: 4'd0,  len: 13'd0,   rnd: 1'b0, ein: 512, eout: 512, elc: 4'd0};
    vecs[5] = '{off: 4'd7,  len: 13'd1,   rnd: 1'b1, ein: 1,   eout: 1,   elc: 4'd1};
    vecs[6] = '{off: 4'd9,  len: 13'd8,   rnd: 1'b0, ein: 1,   eout: 2,   elc: 4'd8};

    reset = 1'b0; cmd_v = 1'b0; cmd_off = 4'd0; cmd_len = '0;
    in_v = 1'b0; in_d = 128'd0; o_r = 1'b0; mon_v = 1'b0; mon_r = 1'b0;
    #1;
    check("rst_cmd_r", 128'(cmd_r), 128'(0));
    check("rst_outs", {122'd0, o_v, in_r, o_e, busy, done, err}, 128'(0));
    check("rst_side", {120'd0, o_a_v, o_a_d, o_c[2:0]}, 128'(0));
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    check("idle_cmd_r", 128'(cmd_r), 128'(1));

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset in the middle of a streaming transfer abandons it immediately.
    accept_cmd(4'd3, 13'd100);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_v = 1'b1; o_r = 1'b1; in_d = 128'(k);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_o_v", 128'(o_v), 128'(0));
    check("midrst_o_a_d", 128'(o_a_d), 128'(0));
    check("midrst_busy", 128'(busy), 128'(0));
    check("midrst_o_e", 128'(o_e), 128'(0));
    in_v = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    check("midrst_idle_cmd_r", 128'(cmd_r), 128'(1));

    // A monitor beat while idle raises a single-cycle error pulse.
    @(negedge clk);
    mon_v = 1'b1; mon_r = 1'b1;
    @(negedge clk);
    mon_v = 1'b0; mon_r = 1'b0;
    #1;
    check("idle_mon_err", 128'(err), 128'(1));
    @(negedge clk); #1;
    check("idle_mon_err_clear", 128'(err), 128'(0));
    check("idle_mon_state", 128'(cmd_r), 128'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
